// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core data port and a debug/loader port.
// The core has priority; a saturating wait counter bounds debug-port starvation.
module dmem_arbiter #(
    parameter int MEM_AW   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_wr,
    input  logic [31:0]       c_addr,
    input  logic [31:0]       c_wdata,
    output logic [31:0]       c_rdata,
    output logic              c_stall,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic              m_wr,
    output logic [MEM_AW-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  wait_cnt_r;
    logic [8:0]  wait_diff_s;
    logic        wait_done_s;
    logic        dbg_gnt_s;
    logic        d_ack_r;
    logic [31:0] d_rdata_r;
    logic        unused_addr_s;

    // Borrow-out of the subtraction tells whether the debug port has waited long enough.
    assign wait_diff_s   = {1'b0, wait_cnt_r} - {1'b0, MAX_WAIT_C};
    assign wait_done_s   = ~wait_diff_s[8];
    assign unused_addr_s = ^{c_addr[31:MEM_AW], d_addr[31:MEM_AW]};

    assign c_rdata = m_rdata;
    assign d_ack   = d_ack_r;
    assign d_rdata = d_rdata_r;

    // Debug grant and next-state decode; the ACK cycle always belongs to the core.
    always_comb begin
        dbg_gnt_s   = 1'b0;
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!rst && d_req && (!c_req || wait_done_s)) begin
                    dbg_gnt_s   = 1'b1;
                    state_nxt_s = ACK;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACK:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Memory port steering; a write is never issued while reset is high.
    always_comb begin
        m_addr  = c_addr[MEM_AW-1:0];
        m_wdata = c_wdata;
        m_wr    = 1'b0;
        c_stall = 1'b0;
        if (rst) begin
            m_wr = 1'b0;
        end else if (dbg_gnt_s) begin
            m_addr  = d_addr[MEM_AW-1:0];
            m_wdata = d_wdata;
            m_wr    = d_wr;
            c_stall = c_req;
        end else begin
            m_wr = c_req & c_wr;
        end
    end

    // State, wait counter and the registered debug response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            wait_cnt_r <= 8'd0;
            d_ack_r    <= 1'b0;
            d_rdata_r  <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            d_ack_r <= dbg_gnt_s;
            if (dbg_gnt_s) begin
                d_rdata_r  <= m_rdata;
                wait_cnt_r <= 8'd0;
            end else if ((state_r == IDLE) && d_req && c_req && (wait_cnt_r != 8'hFF)) begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of grants, waits and memory contents.
module tb_dmem_arbiter;

    localparam int MAX_A = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_wr, d_req, d_wr;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;

    logic [31:0] c_rdata_a, d_rdata_a, m_wdata_a, m_rdata_a;
    logic        c_stall_a, d_ack_a, m_wr_a;
    logic [7:0]  m_addr_a;
    logic [31:0] c_rdata_b, d_rdata_b, m_wdata_b, m_rdata_b;
    logic        c_stall_b, d_ack_b, m_wr_b;
    logic [7:0]  m_addr_b;

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [31:0] ref_mem [0:255];
    logic        mem_clr;

    int          checks;
    int          failures;
    int          m_wcnt;
    logic        m_ack;
    logic [31:0] m_drd;
    logic        was_ack;
    logic        chk_b, exp_b_stall, exp_b_ack;
    logic [31:0] o_crd, o_drd;
    logic        o_stall, o_mwr, o_ack;

    dmem_arbiter #(.MEM_AW(8), .MAX_WAIT(MAX_A)) u_a (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata_a), .c_stall(c_stall_a),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata_a), .d_ack(d_ack_a),
        .m_wr(m_wr_a), .m_addr(m_addr_a), .m_wdata(m_wdata_a), .m_rdata(m_rdata_a)
    );

    dmem_arbiter #(.MEM_AW(8), .MAX_WAIT(0)) u_b (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata_b), .c_stall(c_stall_b),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata_b), .d_ack(d_ack_b),
        .m_wr(m_wr_b), .m_addr(m_addr_b), .m_wdata(m_wdata_b), .m_rdata(m_rdata_b)
    );

    always #5 clk = ~clk;

    assign m_rdata_a = mem_a[m_addr_a];
    assign m_rdata_b = mem_b[m_addr_b];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 32'd0;
                mem_b[i] <= 32'd0;
            end
        end else begin
            if (m_wr_a) mem_a[m_addr_a] <= m_wdata_a;
            if (m_wr_b) mem_b[m_addr_b] <= m_wdata_b;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        logic       gnt;
        logic [7:0] ca, da;
        @(negedge clk);
        ca  = c_addr[7:0];
        da  = d_addr[7:0];
        gnt = !rst && !m_ack && d_req && (!c_req || m_wcnt >= MAX_A);
        chk("c_stall", 32'(c_stall_a), 32'(gnt && c_req));
        chk("m_wr", 32'(m_wr_a), 32'(!rst && (gnt ? d_wr : (c_req && c_wr))));
        chk("m_addr", 32'(m_addr_a), 32'(gnt ? da : ca));
        chk("m_wdata", m_wdata_a, gnt ? d_wdata : c_wdata);
        chk("c_rdata", c_rdata_a, ref_mem[gnt ? da : ca]);
        chk("d_ack", 32'(d_ack_a), 32'(m_ack));
        chk("d_rdata", d_rdata_a, m_drd);
        if (chk_b) begin
            chk("b_c_stall", 32'(c_stall_b), 32'(exp_b_stall));
            chk("b_d_ack", 32'(d_ack_b), 32'(exp_b_ack));
        end
        o_crd   = c_rdata_a;
        o_stall = c_stall_a;
        o_mwr   = m_wr_a;
        o_ack   = d_ack_a;
        o_drd   = d_rdata_a;
        was_ack = m_ack;
        @(posedge clk);
        if (rst) begin
            m_ack  = 1'b0;
            m_wcnt = 0;
            m_drd  = 32'd0;
        end else begin
            if (gnt) begin
                m_drd = ref_mem[da];
                if (d_wr) ref_mem[da] = d_wdata;
                m_wcnt = 0;
            end else begin
                if (c_req && c_wr) ref_mem[ca] = c_wdata;
                if (!m_ack && d_req && c_req && m_wcnt < 255) m_wcnt++;
            end
            m_ack = gnt;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_ack  = 1'b0;
        m_wcnt = 0;
        m_drd  = 32'd0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        m_ack = 1'b0; m_wcnt = 0; m_drd = 32'd0; was_ack = 1'b0;
        chk_b = 1'b0; exp_b_stall = 1'b0; exp_b_ack = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
        mem_clr = 1'b1;
        rst = 1'b1;
        c_req = 1'b1; c_wr = 1'b1; c_addr = 32'h10; c_wdata = 32'h1;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h20; d_wdata = 32'h2;

        // Reset with both ports requesting stores.
        @(posedge clk); #1;
        mem_clr = 1'b0;
        chk("rst_m_wr", 32'(m_wr_a), 32'd0);
        chk("rst_c_stall", 32'(c_stall_a), 32'd0);
        chk("rst_d_ack", 32'(d_ack_a), 32'd0);
        chk("rst_d_rdata", d_rdata_a, 32'd0);
        chk("rst_b_m_wr", 32'(m_wr_b), 32'd0);
        cycle();

        // Core only: store then load.
        rst = 1'b0; d_req = 1'b0;
        c_req = 1'b1; c_wr = 1'b1; c_addr = 32'hABCD_0010; c_wdata = 32'h1234_5678;
        cycle();
        chk("core_st_m_wr", 32'(o_mwr), 32'd1);
        c_wr = 1'b0;
        cycle();
        chk("core_ld_rdata", o_crd, 32'h1234_5678);
        chk("core_ld_stall", 32'(o_stall), 32'd0);

        // Debug only: write then read back.
        c_req = 1'b0; d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h0000_0020; d_wdata = 32'hDEAD_BEEF;
        cycle();
        chk("dbg_wr_m_wr", 32'(o_mwr), 32'd1);
        chk("dbg_wr_noack", 32'(o_ack), 32'd0);
        cycle();
        chk("dbg_wr_ack", 32'(o_ack), 32'd1);
        d_req = 1'b0;
        cycle();
        chk("dbg_ack_pulse", 32'(o_ack), 32'd0);
        d_req = 1'b1; d_wr = 1'b0;
        cycle();
        cycle();
        chk("dbg_rd_ack", 32'(o_ack), 32'd1);
        chk("dbg_rd_data", o_drd, 32'hDEAD_BEEF);
        d_req = 1'b0;
        cycle();

        // Contention with MAX_WAIT=4, two back-to-back debug requests.
        c_req = 1'b1; c_wr = 1'b0; c_addr = 32'h20;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h10;
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 6; k++) begin
                cycle();
                chk("cont_stall", 32'(o_stall), 32'((k == 4) ? 1 : 0));
                chk("cont_ack", 32'(o_ack), 32'((k == 5) ? 1 : 0));
            end
            chk("cont_drdata", o_drd, 32'h1234_5678);
        end
        d_req = 1'b0;
        cycle();

        // MAX_WAIT=0 instance: debug and core alternate.
        do_reset();
        c_req = 1'b1; c_wr = 1'b0; c_addr = 32'h10;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h20;
        chk_b = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_b_stall = (k % 2 == 0);
            exp_b_ack   = (k % 2 == 1);
            cycle();
        end
        chk_b = 1'b0;
        while (d_req && !was_ack) cycle();
        d_req = 1'b0;
        cycle();

        // Reset asserted in the middle of an ACK cycle.
        c_req = 1'b0; d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h20;
        cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_ack_drop", 32'(d_ack_a), 32'd0);
        chk("rst_ack_drdata", d_rdata_a, 32'd0);
        m_ack = 1'b0; m_wcnt = 0; m_drd = 32'd0;
        cycle();
        rst = 1'b0;
        cycle();
        chk("regrant_ack", 32'(d_ack_a), 32'd1);
        chk("regrant_data", d_rdata_a, 32'hDEAD_BEEF);
        cycle();
        d_req = 1'b0;

        // Randomized traffic on both ports.
        for (int n = 0; n < 500; n++) begin
            c_req = ($urandom_range(0, 3) != 0);
            c_wr = 1'($urandom_range(0, 1));
            c_addr = $urandom;
            c_addr[7:4] = 4'h0;
            c_wdata = $urandom;
            if (!d_req || was_ack) begin
                d_req = ($urandom_range(0, 2) == 0);
                d_wr = 1'($urandom_range(0, 1));
                d_addr = $urandom;
                d_addr[7:4] = 4'h0;
                d_wdata = $urandom;
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
